// File: rtl/xadac_pkg.sv
// Shared XADAC request/response types plus the custom-0 vector opcode
// constants and decode helper used by the accelerator-side responder.
package xadac_pkg;

    localparam int unsigned RegDataWidth = 32;
    localparam int unsigned VecDataWidth = 128;
    localparam int unsigned VecElemWidth = 8;
    localparam int unsigned VecSumWidth  = 32;
    localparam int unsigned IdWidth      = 2;
    localparam int unsigned VecNoElem    = VecDataWidth / VecElemWidth;

    localparam logic [6:0] XadacOpcode = 7'b0001011;
    localparam logic [2:0] VdotFunct3  = 3'b000;
    localparam logic [2:0] VaddFunct3  = 3'b001;

    typedef logic [IdWidth-1:0]        IdT;
    typedef logic [RegDataWidth-1:0]   RegDataT;
    typedef logic [VecDataWidth-1:0]   VecDataT;
    typedef logic [VecElemWidth-1:0]   VecElemT;
    typedef logic [2*VecElemWidth-1:0] VecProdT;
    typedef logic [VecSumWidth-1:0]    VecSumT;

    typedef struct packed {
        IdT          id;
        logic [31:0] instr;
    } DecReqT;

    typedef struct packed {
        IdT         id;
        logic       accept;
        logic       rd_clobber;
        logic       vd_clobber;
        logic [1:0] rs_read;
        logic [2:0] vs_read;
    } DecRspT;

    typedef struct packed {
        IdT                id;
        logic [31:0]       instr;
        RegDataT [1:0]     rs;
        VecDataT [2:0]     vs;
    } ExeReqT;

    typedef struct packed {
        IdT         id;
        logic [4:0] rd_addr;
        RegDataT    rd_data;
        logic       rd_write;
        logic [4:0] vd_addr;
        VecDataT    vd_data;
        logic       vd_write;
    } ExeRspT;

    typedef enum logic [1:0] {
        OpNone = 2'd0,
        OpVdot = 2'd1,
        OpVadd = 2'd2
    } VecOpT;

    function automatic VecOpT decodeOp(input logic [31:0] instr);
        VecOpT op;
        op = OpNone;
        if (instr[6:0] == XadacOpcode && instr[31:25] == 7'd0) begin
            case (instr[14:12])
                VdotFunct3: op = OpVdot;
                VaddFunct3: op = OpVadd;
                default:    op = OpNone;
            endcase
        end
        return op;
    endfunction

endpackage

// File: rtl/xadac_vdot_reduce.sv
// Sign-extending adder tree: sums VecNoElem signed products into one VecSumT.
// Latency: combinational.
// Backpressure: none; sits between pipeline registers.
module xadac_vdot_reduce
    import xadac_pkg::*;
(
    input  VecProdT [VecNoElem-1:0] prod,
    output VecSumT                  sum
);

    always_comb begin : bTree
        VecSumT node [VecNoElem];
        for (int i = 0; i < VecNoElem; i++) begin
            node[i] = {{(VecSumWidth - 2*VecElemWidth){prod[i][2*VecElemWidth-1]}}, prod[i]};
        end
        // Pairwise halving keeps the depth at log2(VecNoElem) adders.
        for (int w = VecNoElem / 2; w >= 1; w = w / 2) begin
            for (int i = 0; i < w; i++) begin
                node[i] = node[2*i] + node[2*i+1];
            end
        end
        sum = node[0];
    end

endmodule

// File: rtl/xadac_vdot_unit.sv
// XADAC responder: decodes custom-0 VDOT/VADD and executes accepted ones.
// Latency: decode 1 cycle, execute 2 cycles (S1 products, S2 reduced sum).
// Backpressure: valid/ready; execute buffers at most 2 entries, stalls S1 when S2 is held.
module xadac_vdot_unit
    import xadac_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_ni,

    input  logic   dec_req_valid_i,
    output logic   dec_req_ready_o,
    input  DecReqT dec_req_i,
    output logic   dec_rsp_valid_o,
    input  logic   dec_rsp_ready_i,
    output DecRspT dec_rsp_o,

    input  logic   exe_req_valid_i,
    output logic   exe_req_ready_o,
    input  ExeReqT exe_req_i,
    output logic   exe_rsp_valid_o,
    input  logic   exe_rsp_ready_i,
    output ExeRspT exe_rsp_o
);

    // ---------------- decode path ----------------
    VecOpT  decOp;
    DecRspT decRspNext;

    assign decOp           = decodeOp(dec_req_i.instr);
    assign dec_req_ready_o = !dec_rsp_valid_o || dec_rsp_ready_i;

    always_comb begin
        decRspNext    = '0;
        decRspNext.id = dec_req_i.id;
        case (decOp)
            OpVdot: begin
                decRspNext.accept     = 1'b1;
                decRspNext.rd_clobber = 1'b1;
                decRspNext.rs_read    = 2'b01;
                decRspNext.vs_read    = 3'b011;
            end
            OpVadd: begin
                decRspNext.accept     = 1'b1;
                decRspNext.vd_clobber = 1'b1;
                decRspNext.vs_read    = 3'b011;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dec_rsp_valid_o <= 1'b0;
            dec_rsp_o       <= '0;
        end else if (dec_req_ready_o) begin
            dec_rsp_valid_o <= dec_req_valid_i;
            if (dec_req_valid_i) begin
                dec_rsp_o <= decRspNext;
            end
        end
    end

    // ---------------- execute path, stage 1 ----------------
    VecOpT                  exeOp;
    VecProdT [VecNoElem-1:0] prodNext;
    VecDataT                vaddNext;

    logic                   s1Valid;
    IdT                     s1Id;
    VecOpT                  s1Op;
    logic [4:0]             s1Addr;
    RegDataT                s1Rs0;
    VecProdT [VecNoElem-1:0] s1Prod;
    VecDataT                s1Vadd;
    logic                   s2Adv;

    assign exeOp           = decodeOp(exe_req_i.instr);
    assign s2Adv           = !exe_rsp_valid_o || exe_rsp_ready_i;
    assign exe_req_ready_o = !s1Valid || s2Adv;

    always_comb begin
        prodNext = '0;
        vaddNext = '0;
        for (int i = 0; i < VecNoElem; i++) begin
            VecElemT eA;
            VecElemT eB;
            eA = exe_req_i.vs[0][i*VecElemWidth +: VecElemWidth];
            eB = exe_req_i.vs[1][i*VecElemWidth +: VecElemWidth];
            prodNext[i] = {{VecElemWidth{eA[VecElemWidth-1]}}, eA}
                        * {{VecElemWidth{eB[VecElemWidth-1]}}, eB};
            vaddNext[i*VecElemWidth +: VecElemWidth] = eA + eB;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1Valid <= 1'b0;
            s1Id    <= '0;
            s1Op    <= OpNone;
            s1Addr  <= '0;
            s1Rs0   <= '0;
            s1Prod  <= '0;
            s1Vadd  <= '0;
        end else if (exe_req_ready_o) begin
            s1Valid <= exe_req_valid_i;
            if (exe_req_valid_i) begin
                s1Id   <= exe_req_i.id;
                s1Op   <= exeOp;
                s1Addr <= exe_req_i.instr[11:7];
                s1Rs0  <= exe_req_i.rs[0];
                s1Prod <= prodNext;
                s1Vadd <= vaddNext;
            end
        end
    end

    // ---------------- execute path, stage 2 ----------------
    VecSumT dotSum;
    ExeRspT exeRspNext;

    xadac_vdot_reduce uReduce (
        .prod (s1Prod),
        .sum  (dotSum)
    );

    always_comb begin
        exeRspNext         = '0;
        exeRspNext.id      = s1Id;
        exeRspNext.rd_addr = s1Addr;
        exeRspNext.vd_addr = s1Addr;
        case (s1Op)
            OpVdot: begin
                exeRspNext.rd_data  = s1Rs0 + dotSum;
                exeRspNext.rd_write = 1'b1;
            end
            OpVadd: begin
                exeRspNext.vd_data  = s1Vadd;
                exeRspNext.vd_write = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            exe_rsp_valid_o <= 1'b0;
            exe_rsp_o       <= '0;
        end else if (s2Adv) begin
            exe_rsp_valid_o <= s1Valid;
            if (s1Valid) begin
                exe_rsp_o <= exeRspNext;
            end
        end
    end

endmodule

// File: tb/tb_xadac_vdot_unit.sv
// Directed vectors for xadac_vdot_unit: decode table, execute table, streaming,
// backpressure and mid-operation reset sequences.
module tb_xadac_vdot_unit;
    import xadac_pkg::*;

    logic   clk_i = 1'b0;
    logic   rst_ni;
    logic   dec_req_valid_i, dec_req_ready_o, dec_rsp_valid_o, dec_rsp_ready_i;
    DecReqT dec_req_i;
    DecRspT dec_rsp_o;
    logic   exe_req_valid_i, exe_req_ready_o, exe_rsp_valid_o, exe_rsp_ready_i;
    ExeReqT exe_req_i;
    ExeRspT exe_rsp_o;

    int nVec = 0;
    int nErr = 0;

    always #5 clk_i = ~clk_i;

    xadac_vdot_unit dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .dec_req_valid_i (dec_req_valid_i),
        .dec_req_ready_o (dec_req_ready_o),
        .dec_req_i       (dec_req_i),
        .dec_rsp_valid_o (dec_rsp_valid_o),
        .dec_rsp_ready_i (dec_rsp_ready_i),
        .dec_rsp_o       (dec_rsp_o),
        .exe_req_valid_i (exe_req_valid_i),
        .exe_req_ready_o (exe_req_ready_o),
        .exe_req_i       (exe_req_i),
        .exe_rsp_valid_o (exe_rsp_valid_o),
        .exe_rsp_ready_i (exe_rsp_ready_i),
        .exe_rsp_o       (exe_rsp_o)
    );

    typedef struct {
        logic [31:0] instr;
        IdT          id;
        DecRspT      exp;
    } DecVecT;

    typedef struct {
        logic [31:0] instr;
        IdT          id;
        RegDataT     rs0;
        VecDataT     vs0;
        VecDataT     vs1;
        ExeRspT      exp;
    } ExeVecT;

    localparam int ND = 6;
    localparam int NE = 7;
    DecVecT dv [ND];
    ExeVecT ev [NE];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic DecRspT mkDec(input IdT id, input logic acc, input logic rc,
                                     input logic vc, input logic [1:0] rs, input logic [2:0] vs);
        DecRspT r;
        r.id = id; r.accept = acc; r.rd_clobber = rc; r.vd_clobber = vc;
        r.rs_read = rs; r.vs_read = vs;
        return r;
    endfunction

    function automatic ExeRspT mkRsp(input IdT id, input logic [4:0] a, input RegDataT rd,
                                     input logic rw, input VecDataT vd, input logic vw);
        ExeRspT r;
        r.id = id; r.rd_addr = a; r.vd_addr = a; r.rd_data = rd; r.rd_write = rw;
        r.vd_data = vd; r.vd_write = vw;
        return r;
    endfunction

    function automatic ExeReqT mkReq(input ExeVecT v, input IdT id);
        ExeReqT r;
        r.id    = id;
        r.instr = v.instr;
        r.rs[0] = v.rs0;
        r.rs[1] = 32'hDEADBEEF;
        r.vs[0] = v.vs0;
        r.vs[1] = v.vs1;
        r.vs[2] = {4{32'hA5A5A5A5}};
        return r;
    endfunction

    task automatic sendExe(input ExeReqT r);
        int n;
        @(negedge clk_i);
        exe_req_i       = r;
        exe_req_valid_i = 1'b1;
        n = 0;
        while (!exe_req_ready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (!exe_req_ready_o) begin
            nVec++; nErr++;
            $display("FAIL exe_req_hs: ready stayed %0b required 1", exe_req_ready_o);
        end
        @(posedge clk_i);
        #1 exe_req_valid_i = 1'b0;
    endtask

    task automatic waitExe(input string nm, input ExeRspT exp);
        int n;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!exe_rsp_valid_o && n < 20);
        chk({nm, "_lat"}, 256'(n), 256'(2));
        chk(nm, 256'(exe_rsp_o), 256'(exp));
    endtask

    task automatic sendDec(input DecVecT v);
        int n;
        @(negedge clk_i);
        dec_req_i.instr = v.instr;
        dec_req_i.id    = v.id;
        dec_req_valid_i = 1'b1;
        n = 0;
        while (!dec_req_ready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (!dec_req_ready_o) begin
            nVec++; nErr++;
            $display("FAIL dec_req_hs: ready stayed %0b required 1", dec_req_ready_o);
        end
        @(posedge clk_i);
        #1 dec_req_valid_i = 1'b0;
    endtask

    initial begin
        ExeReqT b0, b1, b2;
        ExeRspT r0, r1, r2;

        dv[0] = '{32'h0000050B, 2'd2, mkDec(2'd2, 1, 1, 0, 2'b01, 3'b011)};
        dv[1] = '{32'h0000150B, 2'd1, mkDec(2'd1, 1, 0, 1, 2'b00, 3'b011)};
        dv[2] = '{32'h0000250B, 2'd3, mkDec(2'd3, 0, 0, 0, 2'b00, 3'b000)};
        dv[3] = '{32'h0200050B, 2'd0, mkDec(2'd0, 0, 0, 0, 2'b00, 3'b000)};
        dv[4] = '{32'h0000050F, 2'd1, mkDec(2'd1, 0, 0, 0, 2'b00, 3'b000)};
        dv[5] = '{32'h0000350B, 2'd2, mkDec(2'd2, 0, 0, 0, 2'b00, 3'b000)};

        ev[0] = '{32'h0000050B, 2'd2, 32'd100, {16{8'hFF}}, {16{8'h02}},
                  mkRsp(2'd2, 5'd10, 32'd68, 1, '0, 0)};
        ev[1] = '{32'h0000150B, 2'd1, 32'd7, {16{8'hF0}}, {16{8'h20}},
                  mkRsp(2'd1, 5'd10, '0, 0, {16{8'h10}}, 1)};
        ev[2] = '{32'h0000028B, 2'd3, 32'hFFFFFFFF, {16{8'h80}}, {16{8'h80}},
                  mkRsp(2'd3, 5'd5, 32'h0003FFFF, 1, '0, 0)};
        ev[3] = '{32'h0000008B, 2'd0, 32'd0, 128'h0F0E0D0C0B0A09080706050403020100, {16{8'h01}},
                  mkRsp(2'd0, 5'd1, 32'd120, 1, '0, 0)};
        ev[4] = '{32'h0000250B, 2'd1, 32'd55, {16{8'hFF}}, {16{8'h02}},
                  mkRsp(2'd1, 5'd10, '0, 0, '0, 0)};
        ev[5] = '{32'h00001F8B, 2'd2, 32'd9, {16{8'h7F}}, {16{8'h01}},
                  mkRsp(2'd2, 5'd31, '0, 0, {16{8'h80}}, 1)};
        ev[6] = '{32'h0000060B, 2'd0, 32'd10, {8{16'h01FE}}, {16{8'h03}},
                  mkRsp(2'd0, 5'd12, 32'hFFFFFFF2, 1, '0, 0)};

        rst_ni          = 1'b0;
        dec_req_valid_i = 1'b0;
        dec_req_i       = '0;
        dec_rsp_ready_i = 1'b1;
        exe_req_valid_i = 1'b0;
        exe_req_i       = '0;
        exe_rsp_ready_i = 1'b1;

        // Reset state, then idle after release.
        repeat (3) @(negedge clk_i);
        chk("rst_dec_vld", 256'(dec_rsp_valid_o), 256'(0));
        chk("rst_exe_vld", 256'(exe_rsp_valid_o), 256'(0));
        chk("rst_dec_rdy", 256'(dec_req_ready_o), 256'(1));
        chk("rst_exe_rdy", 256'(exe_req_ready_o), 256'(1));
        chk("rst_dec_rsp", 256'(dec_rsp_o), 256'(0));
        chk("rst_exe_rsp", 256'(exe_rsp_o), 256'(0));
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
        chk("idle_dec_vld", 256'(dec_rsp_valid_o), 256'(0));
        chk("idle_exe_vld", 256'(exe_rsp_valid_o), 256'(0));

        // Decode table, one request per cycle; response appears the next cycle.
        for (int c = 0; c <= ND; c++) begin
            @(negedge clk_i);
            if (c > 0) begin
                chk($sformatf("dec%0d_vld", c-1), 256'(dec_rsp_valid_o), 256'(1));
                chk($sformatf("dec%0d_rsp", c-1), 256'(dec_rsp_o), 256'(dv[c-1].exp));
            end
            if (c < ND) begin
                dec_req_i.instr = dv[c].instr;
                dec_req_i.id    = dv[c].id;
                dec_req_valid_i = 1'b1;
                chk($sformatf("dec%0d_rdy", c), 256'(dec_req_ready_o), 256'(1));
            end else begin
                dec_req_valid_i = 1'b0;
            end
        end
        @(negedge clk_i);
        chk("dec_drain_vld", 256'(dec_rsp_valid_o), 256'(0));

        // Execute table, one at a time with latency check.
        for (int i = 0; i < NE; i++) begin
            sendExe(mkReq(ev[i], ev[i].id));
            waitExe($sformatf("exe%0d", i), ev[i].exp);
        end

        // Back-to-back stream: one result per cycle, in order.
        for (int c = 0; c <= NE + 1; c++) begin
            @(negedge clk_i);
            if (c >= 2) begin
                chk($sformatf("strm%0d_vld", c-2), 256'(exe_rsp_valid_o), 256'(1));
                chk($sformatf("strm%0d_rsp", c-2), 256'(exe_rsp_o), 256'(ev[c-2].exp));
            end
            if (c < NE) begin
                exe_req_i       = mkReq(ev[c], ev[c].id);
                exe_req_valid_i = 1'b1;
                chk($sformatf("strm%0d_rdy", c), 256'(exe_req_ready_o), 256'(1));
            end else begin
                exe_req_valid_i = 1'b0;
            end
        end
        @(negedge clk_i);
        chk("strm_drain_vld", 256'(exe_rsp_valid_o), 256'(0));

        // Backpressure: two entries buffered, third stalls, order preserved.
        b0 = mkReq(ev[0], 2'd0); r0 = ev[0].exp; r0.id = 2'd0;
        b1 = mkReq(ev[1], 2'd1); r1 = ev[1].exp; r1.id = 2'd1;
        b2 = mkReq(ev[2], 2'd2); r2 = ev[2].exp; r2.id = 2'd2;
        exe_rsp_ready_i = 1'b0;
        sendExe(b0);
        sendExe(b1);
        @(negedge clk_i);
        exe_req_i       = b2;
        exe_req_valid_i = 1'b1;
        chk("bp_stall0", 256'(exe_req_ready_o), 256'(0));
        @(negedge clk_i);
        chk("bp_stall1", 256'(exe_req_ready_o), 256'(0));
        chk("bp_hold_vld", 256'(exe_rsp_valid_o), 256'(1));
        chk("bp_hold_r0", 256'(exe_rsp_o), 256'(r0));
        @(negedge clk_i);
        chk("bp_stable_r0", 256'(exe_rsp_o), 256'(r0));
        exe_rsp_ready_i = 1'b1;
        #1 chk("bp_release_rdy", 256'(exe_req_ready_o), 256'(1));
        @(posedge clk_i);
        #1 exe_req_valid_i = 1'b0;
        @(negedge clk_i);
        chk("bp_r1", 256'(exe_rsp_o), 256'(r1));
        chk("bp_r1_vld", 256'(exe_rsp_valid_o), 256'(1));
        @(negedge clk_i);
        chk("bp_r2", 256'(exe_rsp_o), 256'(r2));
        chk("bp_r2_vld", 256'(exe_rsp_valid_o), 256'(1));
        @(negedge clk_i);
        chk("bp_drain_vld", 256'(exe_rsp_valid_o), 256'(0));

        // Asynchronous reset with both execute stages and the decode register full.
        exe_rsp_ready_i = 1'b0;
        dec_rsp_ready_i = 1'b0;
        sendExe(b0);
        sendExe(b1);
        sendDec(dv[0]);
        @(negedge clk_i);
        chk("ar_full_exe_vld", 256'(exe_rsp_valid_o), 256'(1));
        chk("ar_full_exe_rdy", 256'(exe_req_ready_o), 256'(0));
        chk("ar_full_dec_vld", 256'(dec_rsp_valid_o), 256'(1));
        #2 rst_ni = 1'b0;
        #1;
        chk("ar_exe_vld", 256'(exe_rsp_valid_o), 256'(0));
        chk("ar_dec_vld", 256'(dec_rsp_valid_o), 256'(0));
        chk("ar_exe_rsp", 256'(exe_rsp_o), 256'(0));
        chk("ar_exe_rdy", 256'(exe_req_ready_o), 256'(1));
        @(negedge clk_i);
        rst_ni          = 1'b1;
        exe_rsp_ready_i = 1'b1;
        dec_rsp_ready_i = 1'b1;
        sendExe(mkReq(ev[2], ev[2].id));
        waitExe("ar_post", ev[2].exp);
        @(negedge clk_i);
        chk("ar_post_drain", 256'(exe_rsp_valid_o), 256'(0));
        sendDec(dv[1]);
        @(negedge clk_i);
        chk("ar_post_dec_vld", 256'(dec_rsp_valid_o), 256'(1));
        chk("ar_post_dec", 256'(dec_rsp_o), 256'(dv[1].exp));

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
